// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD splitter
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  // 64-bit so that 10^10 (largest DIGITS) is representable
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - add-3 correction applied to one BCD digit before each shift
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= DIGIT_W'(ADJ_THRESH)) begin
      dout = din + DIGIT_W'(ADJ_ADD);
    end
  end

endmodule

// File: rtl/bcd_splitter.sv
// rtl/bcd_splitter.sv - iterative double-dabble binary to packed BCD converter, one bit per clock
module bcd_splitter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin_i,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                ovf
);

  localparam int          CNT_W     = $clog2(WIDTH + 1);
  localparam int          BCD_W     = DIGIT_W * DIGITS;
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_hold_q, ovf_hold_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shifted;
  logic [63:0]        bin_ext;
  logic               last_iter;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q[g*DIGIT_W +: DIGIT_W]),
      .dout (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Shifting out the top bit of the top digit drops the decimal carry, so the
  // accumulator naturally holds the value modulo 10^DIGITS.
  assign acc_shifted = {acc_adj[BCD_W-2:0], sh_q[WIDTH-1]};
  assign bin_ext     = 64'(bin_i);
  assign last_iter   = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == CONV);
    done  = done_q;
    bcd_o = bcd_q;
    ovf   = ovf_q;
  end

  always_comb begin
    sh_d       = sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_hold_d = ovf_hold_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        sh_d       = bin_i;
        acc_d      = '0;
        cnt_d      = CNT_W'(WIDTH);
        ovf_hold_d = (bin_ext >= OVF_LIMIT);
      end
    end else begin
      sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      acc_d = acc_shifted;
      cnt_d = cnt_q - CNT_W'(1);
      if (last_iter) begin
        bcd_d  = acc_shifted;
        ovf_d  = ovf_hold_q;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_hold_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_hold_q <= ovf_hold_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_bcd_splitter.sv
// tb/tb_bcd_splitter.sv - scoreboard bench for bcd_splitter at three parameter points
module tb_bcd_splitter;

  typedef struct {
    logic [39:0] bcd;
    bit          ovf;
    longint      cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     hold_chk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a, last_a;
  logic        start_b, busy_b, done_b, ovf_b;
  logic [7:0]  bin_b, bcd_b, last_b;
  logic        start_c, busy_c, done_c, ovf_c;
  logic [11:0] bin_c;
  logic [15:0] bcd_c, last_c;

  exp_t q_a[$], q_b[$], q_c[$];
  exp_t ea, eb, ec;

  bcd_splitter #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_i(bin_a),
    .busy(busy_a), .done(done_a), .bcd_o(bcd_a), .ovf(ovf_a));
  bcd_splitter #(.WIDTH(8), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_i(bin_b),
    .busy(busy_b), .done(done_b), .bcd_o(bcd_b), .ovf(ovf_b));
  bcd_splitter #(.WIDTH(12), .DIGITS(4)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .bin_i(bin_c),
    .busy(busy_c), .done(done_c), .bcd_o(bcd_c), .ovf(ovf_c));

  // Reference: decimal digits of v mod 10^d, result due w edges after acceptance
  function automatic exp_t model(input longint v, input int d, input longint acc_cyc, input int w);
    exp_t   e;
    longint lim;
    longint r;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    r = v % lim;
    e.bcd = '0;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.ovf = (v >= lim);
    e.cyc = acc_cyc + w;
    return e;
  endfunction

  function automatic bit digits_ok(input logic [39:0] v, input int d);
    for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      cmp("A busy_done_overlap", 64'(busy_a), 64'd0);
      cmp("A digit_range", 64'(digits_ok(40'(bcd_a), 3)), 64'd1);
      if (q_a.size() == 0) fail_now("A unexpected_done: got done=1 want done=0");
      else begin
        ea = q_a.pop_front();
        cmp("A bcd", 64'(bcd_a), 64'(ea.bcd[11:0]));
        cmp("A ovf", 64'(ovf_a), 64'(ea.ovf));
        cmp("A done_cycle", 64'(cyc), 64'(ea.cyc));
        last_a = ea.bcd[11:0];
      end
    end else if (hold_chk) cmp("A hold", 64'(bcd_a), 64'(last_a));
  end

  always @(negedge clk) begin
    if (done_b) begin
      cmp("B busy_done_overlap", 64'(busy_b), 64'd0);
      cmp("B digit_range", 64'(digits_ok(40'(bcd_b), 2)), 64'd1);
      if (q_b.size() == 0) fail_now("B unexpected_done: got done=1 want done=0");
      else begin
        eb = q_b.pop_front();
        cmp("B bcd", 64'(bcd_b), 64'(eb.bcd[7:0]));
        cmp("B ovf", 64'(ovf_b), 64'(eb.ovf));
        cmp("B done_cycle", 64'(cyc), 64'(eb.cyc));
        last_b = eb.bcd[7:0];
      end
    end else if (hold_chk) cmp("B hold", 64'(bcd_b), 64'(last_b));
  end

  always @(negedge clk) begin
    if (done_c) begin
      cmp("C busy_done_overlap", 64'(busy_c), 64'd0);
      cmp("C digit_range", 64'(digits_ok(40'(bcd_c), 4)), 64'd1);
      if (q_c.size() == 0) fail_now("C unexpected_done: got done=1 want done=0");
      else begin
        ec = q_c.pop_front();
        cmp("C bcd", 64'(bcd_c), 64'(ec.bcd[15:0]));
        cmp("C ovf", 64'(ovf_c), 64'(ec.ovf));
        cmp("C done_cycle", 64'(cyc), 64'(ec.cyc));
        last_c = ec.bcd[15:0];
      end
    end else if (hold_chk) cmp("C hold", 64'(bcd_c), 64'(last_c));
  end

  // Each conv task perturbs start/bin_i during CONV; those must be ignored.
  task automatic conv_a(input logic [7:0] v);
    int t;
    t = 0;
    while (busy_a && t < 50) begin @(posedge clk); #1; t++; end
    if (busy_a) fail_now("A idle_timeout: got busy=1 want busy=0");
    start_a = 1'b1; bin_a = v;
    @(posedge clk); #1;
    q_a.push_back(model(longint'(v), 3, cyc, 8));
    repeat (7) begin
      start_a = 1'($urandom); bin_a = 8'($urandom);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
  endtask

  task automatic conv_b(input logic [7:0] v);
    int t;
    t = 0;
    while (busy_b && t < 50) begin @(posedge clk); #1; t++; end
    if (busy_b) fail_now("B idle_timeout: got busy=1 want busy=0");
    start_b = 1'b1; bin_b = v;
    @(posedge clk); #1;
    q_b.push_back(model(longint'(v), 2, cyc, 8));
    repeat (7) begin
      start_b = 1'($urandom); bin_b = 8'($urandom);
      @(posedge clk); #1;
    end
    start_b = 1'b0;
  endtask

  task automatic conv_c(input logic [11:0] v);
    int t;
    t = 0;
    while (busy_c && t < 50) begin @(posedge clk); #1; t++; end
    if (busy_c) fail_now("C idle_timeout: got busy=1 want busy=0");
    start_c = 1'b1; bin_c = v;
    @(posedge clk); #1;
    q_c.push_back(model(longint'(v), 4, cyc, 12));
    repeat (11) begin
      start_c = 1'($urandom); bin_c = 12'($urandom);
      @(posedge clk); #1;
    end
    start_c = 1'b0;
  endtask

  initial begin
    longint k;
    int     t;
    rst = 1'b1;
    start_a = 1'b1; bin_a = 8'd99;
    start_b = 1'b1; bin_b = 8'd99;
    start_c = 1'b1; bin_c = 12'd99;
    last_a = '0; last_b = '0; last_c = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp("A reset busy", 64'(busy_a), 64'd0);
    cmp("A reset done", 64'(done_a), 64'd0);
    cmp("A reset bcd", 64'(bcd_a), 64'd0);
    cmp("A reset ovf", 64'(ovf_a), 64'd0);
    cmp("B reset busy", 64'(busy_b), 64'd0);
    cmp("B reset bcd", 64'(bcd_b), 64'd0);
    cmp("C reset busy", 64'(busy_c), 64'd0);
    cmp("C reset bcd", 64'(bcd_c), 64'd0);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rst = 1'b0;
    hold_chk = 1'b1;

    conv_a(8'd0);
    conv_a(8'd255);
    conv_a(8'd59);

    // start held high: 17 then 42 back-to-back, WIDTH+1 cycles apart
    t = 0;
    while (busy_a && t < 50) begin @(posedge clk); #1; t++; end
    start_a = 1'b1; bin_a = 8'd17;
    @(posedge clk); #1;
    k = cyc;
    q_a.push_back(model(64'd17, 3, k, 8));
    q_a.push_back(model(64'd42, 3, k + 9, 8));
    bin_a = 8'd42;
    repeat (9) @(posedge clk);
    #1;
    start_a = 1'b0;

    // abort a conversion of 200 four cycles in
    t = 0;
    while (busy_a && t < 50) begin @(posedge clk); #1; t++; end
    start_a = 1'b1; bin_a = 8'd200;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    last_a = '0; last_b = '0; last_c = '0;
    cmp("A abort busy", 64'(busy_a), 64'd0);
    cmp("A abort done", 64'(done_a), 64'd0);
    cmp("A abort bcd", 64'(bcd_a), 64'd0);
    cmp("A abort ovf", 64'(ovf_a), 64'd0);
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    conv_a(8'd7);

    conv_b(8'd123);
    conv_b(8'd99);
    conv_b(8'd100);

    conv_c(12'd9999);
    conv_c(12'd4095);
    for (int i = 0; i < 1000; i++) conv_c(12'($urandom_range(0, 4095)));

    t = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (q_a.size() != 0) fail_now("A drain_timeout: expected results never produced");
    if (q_b.size() != 0) fail_now("B drain_timeout: expected results never produced");
    if (q_c.size() != 0) fail_now("C drain_timeout: expected results never produced");
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
